bcd_to_bin_seq: RTL and testbench

//  Sequential 5-digit BCD to 16-bit binary converter (reverse double-dabble), the inverse of the

---
 rtl/bcd_to_bin_seq.sv | 122 ++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD to binary converter (reverse double-dabble), one bit per clock.
// A 5-digit BCD value becomes a 16-bit result, saturating with an ovf flag and flagging invalid digits.
module bcd_to_bin_seq #(
    parameter int NDIG = 5,
    parameter int NBIN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*NDIG-1:0] bcd_in,
    output logic              busy,
    output logic              done,
    output logic [NBIN-1:0]   bin_out,
    output logic              ovf,
    output logic              err
);

    localparam int BW = 4 * NDIG;
    localparam int RW = NBIN + 1;
    localparam int ZW = BW + RW;
    localparam int CW = $clog2(RW);
    localparam logic [CW-1:0] LAST = CW'(NBIN);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [ZW-1:0]   z;
    logic [ZW-1:0]   z_next;
    logic            err_l;
    logic [NBIN+1:0] res_next;

    // One reverse double-dabble step: shift right, then pull every BCD nibble >= 8 down by 3.
    function automatic logic [ZW-1:0] iterate(input logic [ZW-1:0] zin);
        logic [ZW-1:0] s;
        s = zin >> 1;
        for (int i = 0; i < NDIG; i++) begin
            if (s[RW+4*i+3]) begin
                s[RW+4*i +: 4] = s[RW+4*i +: 4] - 4'd3;
            end
        end
        return s;
    endfunction

    function automatic logic digits_invalid(input logic [BW-1:0] b);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (b[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // Result packed as {err, ovf, bin}; an invalid input always wins over overflow.
    function automatic logic [NBIN+1:0] finalize(input logic bad, input logic [RW-1:0] val);
        logic [NBIN+1:0] r;
        if (bad) begin
            r = {1'b1, 1'b0, {NBIN{1'b0}}};
        end else if (val[NBIN]) begin
            r = {1'b0, 1'b1, {NBIN{1'b1}}};
        end else begin
            r = {1'b0, 1'b0, val[NBIN-1:0]};
        end
        return r;
    endfunction

    assign z_next   = iterate(z);
    assign res_next = finalize(err_l, z_next[RW-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            z       <= '0;
            err_l   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        z     <= {bcd_in, {RW{1'b0}}};
                        cnt   <= '0;
                        err_l <= digits_invalid(bcd_in);
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    z   <= z_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        {err, ovf, bin_out} <= res_next;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Randomized and directed bench for bcd_to_bin_seq, checked against a decimal-arithmetic model.
module tb_bcd_to_bin_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [19:0] bcd_in;
    logic        busy;
    logic        done;
    logic [15:0] bin_out;
    logic        ovf;
    logic        err;

    int total = 0;
    int bad = 0;

    bcd_to_bin_seq #(.NDIG(5), .NBIN(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bcd_in (bcd_in),
        .busy   (busy),
        .done   (done),
        .bin_out(bin_out),
        .ovf    (ovf),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {err, ovf, bin} from plain decimal arithmetic.
    function automatic logic [17:0] model(input logic [19:0] b);
        int v;
        bit bad_d;
        v = 0;
        bad_d = 0;
        for (int d = 4; d >= 0; d--) begin
            int dig;
            dig = int'(b[d*4 +: 4]);
            if (dig > 9) bad_d = 1;
            v = v * 10 + dig;
        end
        if (bad_d) return 18'h20000;
        if (v > 65535) return 18'h1FFFF;
        return {2'b00, 16'(v)};
    endfunction

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] b;
        int t;
        t = v;
        for (int d = 0; d < 5; d++) begin
            b[d*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction

    function automatic logic [19:0] rand_bcd();
        if ($urandom_range(7) == 0) return 20'($urandom);
        return to_bcd(int'($urandom_range(99999)));
    endfunction

    // Drives one conversion from IDLE and returns after the edge that drops busy.
    task automatic run_conv(input logic [19:0] b, output int lat, output logic [17:0] res,
                            output logic busy_end, output int busy_gaps);
        @(negedge clk);
        bcd_in = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bcd_in = 20'($urandom);
        lat = 0;
        busy_gaps = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_gaps++;
            @(posedge clk);
            #1;
            lat++;
        end
        res = {err, ovf, bin_out};
        @(posedge clk);
        #1;
        busy_end = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bcd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, bin_out, ovf, err} !== 19'h0) begin
            bad++;
            $display("FAIL reset_state got=%h want=0", {busy, done, bin_out, ovf, err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL idle_no_start got=%b want=00", {busy, done});
        end
    endtask

    task automatic test_directed();
        logic [19:0] vec [7] = '{20'h00000, 20'h01234, 20'h65535, 20'h65536,
                                 20'h99999, 20'h1A234, 20'h00042};
        logic [17:0] exp [7] = '{18'h00000, 18'h004D2, 18'h0FFFF, 18'h1FFFF,
                                 18'h1FFFF, 18'h20000, 18'h0002A};
        int lat, gaps;
        logic [17:0] res;
        logic be;
        for (int i = 0; i < 7; i++) begin
            run_conv(vec[i], lat, res, be, gaps);
            total++;
            if (res !== exp[i]) begin
                bad++;
                $display("FAIL directed_%h result got=%h want=%h", vec[i], res, exp[i]);
            end
            total++;
            if (lat !== 17 || gaps !== 0 || be !== 1'b0) begin
                bad++;
                $display("FAIL directed_%h timing got lat=%0d gaps=%0d busy_end=%b want 17/0/0",
                         vec[i], lat, gaps, be);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] q[$];
        logic [19:0] b;
        int dones;
        @(negedge clk);
        start = 1'b1;
        dones = 0;
        for (int k = 0; k < 76; k++) begin
            bcd_in = rand_bcd();
            if (k % 19 == 0) q.push_back(bcd_in);
            @(posedge clk);
            #1;
            total++;
            if (done !== (k % 19 == 17) || busy !== (k % 19 != 18)) begin
                bad++;
                $display("FAIL b2b_handshake edge=%0d got done=%b busy=%b want done=%b busy=%b",
                         k, done, busy, (k % 19 == 17), (k % 19 != 18));
            end
            if (done === 1'b1 && q.size() > 0) begin
                dones++;
                b = q.pop_front();
                total++;
                if ({err, ovf, bin_out} !== model(b)) begin
                    bad++;
                    $display("FAIL b2b_result in=%h got=%h want=%h", b, {err, ovf, bin_out}, model(b));
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        total++;
        if (dones !== 4) begin
            bad++;
            $display("FAIL b2b_done_count got=%0d want=4", dones);
        end
    endtask

    task automatic test_reset_mid();
        int lat, gaps, spurious;
        logic [17:0] res;
        logic be;
        run_conv(20'h99999, lat, res, be, gaps);
        @(negedge clk);
        bcd_in = 20'h12345;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, bin_out, ovf, err} !== 19'h0) begin
            bad++;
            $display("FAIL reset_mid_async got=%h want=0", {busy, done, bin_out, ovf, err});
        end
        spurious = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) spurious++;
        end
        total++;
        if (spurious !== 0) begin
            bad++;
            $display("FAIL reset_mid_hold got=%0d active cycles want=0", spurious);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_conv(20'h00100, lat, res, be, gaps);
        total++;
        if (res !== 18'h00064 || lat !== 17) begin
            bad++;
            $display("FAIL reset_mid_after got res=%h lat=%0d want res=00064 lat=17", res, lat);
        end
    endtask

    task automatic test_random();
        logic [19:0] edge_vals [8] = '{20'h00001, 20'h09999, 20'h10000, 20'h59999,
                                      20'h65534, 20'h65539, 20'h65540, 20'h90000};
        logic [19:0] b;
        int lat, gaps;
        logic [17:0] res;
        logic be;
        for (int i = 0; i < 308; i++) begin
            b = (i < 8) ? edge_vals[i] : rand_bcd();
            run_conv(b, lat, res, be, gaps);
            total++;
            if (res !== model(b) || lat !== 17 || gaps !== 0 || be !== 1'b0) begin
                bad++;
                $display("FAIL random_%h got res=%h lat=%0d gaps=%0d busy_end=%b want res=%h lat=17",
                         b, res, lat, gaps, be, model(b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
